// File: rtl/decode_operand_bypass.sv
// Decode-stage operand bypass and load-use hazard unit: per-port MEM/WB forwarding,
// registered D/E operands, a RUN/STALL tracker with a sticky watchdog and a stall counter.
module decode_operand_bypass #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int NPORTS    = 2,
  parameter int STALL_MAX = 15,
  parameter int CNT_W     = 16,
  localparam int RC_W     = $clog2(STALL_MAX + 2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NPORTS*REG_W-1:0]  id_rs,
  input  logic [NPORTS*DATA_W-1:0] rf_rd,
  input  logic                     ex_we,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic                     ex_is_load,
  input  logic                     mem_we,
  input  logic [REG_W-1:0]         mem_rd,
  input  logic                     mem_is_load,
  input  logic [DATA_W-1:0]        mem_aluout,
  input  logic                     wb_we,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic [DATA_W-1:0]        wb_result,
  output logic                     stall_d,
  output logic                     op_valid,
  output logic [NPORTS*DATA_W-1:0] op_data,
  output logic [NPORTS*2-1:0]      fwd_sel,
  output logic [CNT_W-1:0]         stall_count,
  output logic                     wdog_err,
  output logic                     dbgState,
  output logic [RC_W-1:0]          dbgRunCount
);

  // Handshake: op_valid pulses for one cycle per accepted instruction; decode is only
  // accepted when id_valid && !stall_d, a stalled cycle emits a bubble (op_valid=0).

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic [RC_W-1:0] RC_SAT = RC_W'(STALL_MAX + 1);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} stateT;

  stateT                     state, stateNext;
  logic [RC_W-1:0]           runCount, runCountNext;
  logic [NPORTS-1:0]         hazard;
  logic [NPORTS*DATA_W-1:0]  selData;
  logic [NPORTS*2-1:0]       selCode;
  logic [REG_W-1:0]          rs;

  // Source priority MEM > WB > RF; register 0 is a hard zero and never forwarded.
  always_comb begin
    hazard  = '0;
    selData = '0;
    selCode = '0;
    rs      = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rs = id_rs[p*REG_W +: REG_W];
      if (rs == '0) begin
        selCode[p*2 +: 2]        = SEL_ZERO;
        selData[p*DATA_W +: DATA_W] = '0;
      end else if (mem_we && mem_rd == rs) begin
        selCode[p*2 +: 2]        = SEL_MEM;
        selData[p*DATA_W +: DATA_W] = mem_aluout;
      end else if (wb_we && wb_rd == rs) begin
        selCode[p*2 +: 2]        = SEL_WB;
        selData[p*DATA_W +: DATA_W] = wb_result;
      end else begin
        selCode[p*2 +: 2]        = SEL_RF;
        selData[p*DATA_W +: DATA_W] = rf_rd[p*DATA_W +: DATA_W];
      end
      // A load in MEM shadows any older WB match for the same register.
      hazard[p] = id_valid && (rs != '0) &&
                  ((ex_we && ex_is_load && ex_rd == rs) ||
                   (mem_we && mem_is_load && mem_rd == rs));
    end
  end

  assign stall_d = !reset && (|hazard);

  always_comb begin
    stateNext    = state;
    runCountNext = runCount;
    case (state)
      RUN: begin
        if (stall_d) begin
          stateNext    = STALL;
          runCountNext = RC_W'(1);
        end
      end
      STALL: begin
        if (stall_d) begin
          if (runCount != RC_SAT) runCountNext = runCount + RC_W'(1);
        end else begin
          stateNext    = RUN;
          runCountNext = '0;
        end
      end
      default: begin
        stateNext    = RUN;
        runCountNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      runCount <= '0;
      wdog_err <= 1'b0;
    end else begin
      state    <= stateNext;
      runCount <= runCountNext;
      if (stall_d && runCountNext == RC_SAT) wdog_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_d && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_data  <= '0;
      fwd_sel  <= '0;
    end else if (stall_d) begin
      op_valid <= 1'b0;
    end else if (id_valid) begin
      op_valid <= 1'b1;
      op_data  <= selData;
      fwd_sel  <= selCode;
    end else begin
      op_valid <= 1'b0;
    end
  end

  assign dbgState    = state;
  assign dbgRunCount = runCount;

endmodule

// File: tb/tb_decode_operand_bypass.sv
// Directed plus small random bench for decode_operand_bypass; three instances share
// stimulus to cover the default, a short watchdog and a narrow stall counter.
module tb_decode_operand_bypass;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NPORTS = 2;
  localparam int EXP_W  = 1 + 2*NPORTS + NPORTS*DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [NPORTS*REG_W-1:0]  id_rs = '0;
  logic [NPORTS*DATA_W-1:0] rf_rd = '0;
  logic ex_we = 1'b0, ex_is_load = 1'b0, mem_we = 1'b0, mem_is_load = 1'b0, wb_we = 1'b0;
  logic [REG_W-1:0] ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic [DATA_W-1:0] mem_aluout = '0, wb_result = '0;

  logic stall_d, op_valid, wdog_err, dbgState;
  logic [63:0] op_data;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_count;
  logic [4:0]  dbgRunCount;

  logic wdStall, wdValid, wdErr, wdState;
  logic [63:0] wdData;
  logic [3:0]  wdSel;
  logic [15:0] wdCount;
  logic [2:0]  wdRc;

  logic cnStall, cnValid, cnErr, cnState;
  logic [63:0] cnData;
  logic [3:0]  cnSel;
  logic [3:0]  cnCount;
  logic [4:0]  cnRc;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [63:0] holdData = '0;
  logic [3:0]  holdSel = '0;

  decode_operand_bypass dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .rf_rd(rf_rd),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_aluout(mem_aluout),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall_d(stall_d), .op_valid(op_valid), .op_data(op_data), .fwd_sel(fwd_sel),
    .stall_count(stall_count), .wdog_err(wdog_err), .dbgState(dbgState), .dbgRunCount(dbgRunCount)
  );

  decode_operand_bypass #(.STALL_MAX(3)) dutWd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .rf_rd(rf_rd),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_aluout(mem_aluout),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall_d(wdStall), .op_valid(wdValid), .op_data(wdData), .fwd_sel(wdSel),
    .stall_count(wdCount), .wdog_err(wdErr), .dbgState(wdState), .dbgRunCount(wdRc)
  );

  decode_operand_bypass #(.CNT_W(4)) dutCnt (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .rf_rd(rf_rd),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_aluout(mem_aluout),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall_d(cnStall), .op_valid(cnValid), .op_data(cnData), .fwd_sel(cnSel),
    .stall_count(cnCount), .wdog_err(cnErr), .dbgState(cnState), .dbgRunCount(cnRc)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  // Driver and scoreboard tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input logic v, input logic [3:0] sel, input logic [63:0] data);
    exp_q.push_back({v, sel, data});
    holdData = data;
    holdSel  = sel;
  endtask

  task automatic expect_bubble();
    exp_q.push_back({1'b0, holdSel, holdData});
  endtask

  task automatic expect_from_inputs();
    logic [63:0] d;
    logic [3:0]  s;
    logic [4:0]  r;
    d = '0;
    s = '0;
    for (int p = 0; p < NPORTS; p++) begin
      r = id_rs[p*REG_W +: REG_W];
      if (r == 5'd0)                  begin s[p*2 +: 2] = 2'b11; d[p*32 +: 32] = 32'h0; end
      else if (mem_we && mem_rd == r) begin s[p*2 +: 2] = 2'b10; d[p*32 +: 32] = mem_aluout; end
      else if (wb_we && wb_rd == r)   begin s[p*2 +: 2] = 2'b01; d[p*32 +: 32] = wb_result; end
      else                            begin s[p*2 +: 2] = 2'b00; d[p*32 +: 32] = rf_rd[p*32 +: 32]; end
    end
    expect_op(1'b1, s, d);
  endtask

  task automatic step(input string tag);
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty queue expected pending entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".valid"}, 64'(op_valid), 64'(e[EXP_W-1]));
      check({tag, ".sel"},   64'(fwd_sel),  64'(e[EXP_W-2 -: 4]));
      check({tag, ".data"},  op_data,       e[63:0]);
    end
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    check("rst_valid", 64'(op_valid), 64'd0);
    check("rst_data", op_data, 64'd0);
    check("rst_sel", 64'(fwd_sel), 64'd0);
    check("rst_count", 64'(stall_count), 64'd0);
    check("rst_wdog", 64'(wdog_err), 64'd0);
    check("rst_stall", 64'(stall_d), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a stall
    id_valid = 1'b1; id_rs = {5'd7, 5'd2}; rf_rd = {32'h0000_00AA, 32'h0000_0022};
    ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
    #1 check("t1_stall_d", 64'(stall_d), 64'd1);
    for (int k = 0; k < 3; k++) begin
      expect_bubble();
      step("t1_stall");
    end
    check("t1_count", 64'(stall_count), 64'd3);
    check("t1_rc", 64'(dbgRunCount), 64'd3);
    check("t1_state", 64'(dbgState), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_valid", 64'(op_valid), 64'd0);
    check("t1_rst_data", op_data, 64'd0);
    check("t1_rst_sel", 64'(fwd_sel), 64'd0);
    check("t1_rst_count", 64'(stall_count), 64'd0);
    check("t1_rst_wdog", 64'(wdog_err), 64'd0);
    check("t1_rst_stall", 64'(stall_d), 64'd0);
    check("t1_rst_state", 64'(dbgState), 64'd0);
    check("t1_rst_rc", 64'(dbgRunCount), 64'd0);
    ex_we = 1'b0; ex_is_load = 1'b0;
    holdData = '0; holdSel = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t1_run", 64'(dbgState), 64'd0);

    // MEM beats WB on the same register
    id_rs = {5'd3, 5'd5}; rf_rd = {32'h0000_AAAA, 32'h0000_5555};
    mem_we = 1'b1; mem_rd = 5'd5; mem_aluout = 32'hDEAD_BEEF;
    wb_we = 1'b1; wb_rd = 5'd5; wb_result = 32'h0000_1111;
    #1 check("t2_stall_d", 64'(stall_d), 64'd0);
    expect_op(1'b1, 4'b0010, {32'h0000_AAAA, 32'hDEAD_BEEF});
    step("t2_mem");
    mem_we = 1'b0; id_rs = {5'd5, 5'd5};
    expect_op(1'b1, 4'b0101, {32'h0000_1111, 32'h0000_1111});
    step("t2_wb_dual");
    id_valid = 1'b0;
    expect_bubble();
    step("t2_idle");

    // Load-use: EX load, then MEM load shadowing stale WB, then WB forward
    id_valid = 1'b1; id_rs = {5'd7, 5'd2}; rf_rd = {32'h0000_AAAA, 32'h0000_0022};
    wb_we = 1'b0; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
    #1 check("t3_ex_stall", 64'(stall_d), 64'd1);
    expect_bubble();
    step("t3_ex");
    check("t3_state", 64'(dbgState), 64'd1);
    ex_we = 1'b0; ex_is_load = 1'b0;
    mem_we = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd7; mem_aluout = 32'h0000_0BAD;
    wb_we = 1'b1; wb_rd = 5'd7; wb_result = 32'h0000_9999;
    #1 check("t3_mem_stall", 64'(stall_d), 64'd1);
    expect_bubble();
    step("t3_mem");
    mem_we = 1'b0; mem_is_load = 1'b0; wb_result = 32'h0000_1234;
    #1 check("t3_wb_stall", 64'(stall_d), 64'd0);
    expect_op(1'b1, 4'b0100, {32'h0000_1234, 32'h0000_0022});
    step("t3_wb");
    check("t3_count", 64'(stall_count), 64'd2);
    check("t3_run", 64'(dbgState), 64'd0);

    // Register 0 never forwards and never stalls
    id_rs = '0; rf_rd = {32'h1111_1111, 32'h2222_2222};
    mem_we = 1'b1; mem_rd = 5'd0; mem_aluout = 32'h0000_FFFF;
    wb_we = 1'b1; wb_rd = 5'd0; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
    #1 check("t4_stall_d", 64'(stall_d), 64'd0);
    expect_op(1'b1, 4'b1111, 64'd0);
    step("t4_zero");

    // Random forwarding without loads
    ex_we = 1'b0; ex_is_load = 1'b0; mem_is_load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      id_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      mem_we = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 3));
      wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3));
      mem_aluout = $urandom; wb_result = $urandom;
      rf_rd = {$urandom, $urandom};
      #1 check("rnd_stall_d", 64'(stall_d), 64'd0);
      expect_from_inputs();
      step("rnd");
    end

    // Long stall: watchdog and counter saturation
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    holdData = '0; holdSel = '0;
    id_rs = {5'd7, 5'd2}; rf_rd = {32'h0000_0077, 32'h0000_0022};
    mem_we = 1'b0; wb_we = 1'b0; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
    for (int k = 1; k <= 20; k++) begin
      expect_bubble();
      step("t5_stall");
      if (k <= 5) check("t5_wdog_short", 64'(wdErr), 64'(k >= 4));
      if (k == 14) check("t6_cnt14", 64'(cnCount), 64'd14);
      if (k == 15) check("t5_wdog_main15", 64'(wdog_err), 64'd0);
      if (k == 16) check("t5_wdog_main16", 64'(wdog_err), 64'd1);
      if (k == 20) begin
        check("t6_cnt_sat", 64'(cnCount), 64'd15);
        check("t6_count_main", 64'(stall_count), 64'd20);
        check("t5_rc_sat", 64'(wdRc), 64'd4);
      end
    end
    ex_we = 1'b0; ex_is_load = 1'b0;
    expect_op(1'b1, 4'b0000, {32'h0000_0077, 32'h0000_0022});
    step("t5_clear");
    check("t5_wdog_sticky", 64'(wdErr), 64'd1);
    check("t5_wdog_main_sticky", 64'(wdog_err), 64'd1);
    check("t5_rc_clear", 64'(wdRc), 64'd0);
    check("t6_cnt_hold", 64'(cnCount), 64'd15);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
